instruction_fetch_unit: RTL and testbench

Sequencer on the read side of the instruction RAM. It drives the RAM address and enable, reads one 8-bit instruction per fetch, and hands each instruction to the downstream controller over a valid/ready handshake. It stops when it reads the END_OF_PROGRAM sentinel, or when the address space is exhausted.

---
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction RAM read sequencer with valid/ready delivery
module instruction_fetch_unit #(
    parameter logic [7:0] END_OF_PROGRAM = 8'hFF,
    parameter logic [7:0] START_ADDR     = 8'd0,
    parameter logic [7:0] MAX_ADDR       = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] instr_address,
    output logic       instr_enable,
    input  logic [7:0] instr_data,
    output logic [7:0] instr_out,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [7:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   last_flag;
    logic   is_eop;
    logic   accept;

    assign is_eop = (instr_data == END_OF_PROGRAM);
    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = FETCH;
            FETCH:      state_nx = is_eop ? DONE : HOLD;
            HOLD:       if (accept) state_nx = last_flag ? DONE : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        instr_enable = (state == FETCH);
        busy         = (state == FETCH) || (state == HOLD);
        done         = (state == DONE);
    end

    // last_flag marks that MAX_ADDR was just consumed, so the address never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_address <= 8'd0;
            instr_out     <= 8'd0;
            instr_valid   <= 1'b0;
            overrun       <= 1'b0;
            instr_count   <= 8'd0;
            last_flag     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        instr_address <= START_ADDR;
                        instr_count   <= 8'd0;
                        overrun       <= 1'b0;
                        last_flag     <= 1'b0;
                    end
                end
                FETCH: begin
                    if (!is_eop) begin
                        instr_out   <= instr_data;
                        instr_valid <= 1'b1;
                        if (instr_address == MAX_ADDR) begin
                            last_flag <= 1'b1;
                        end else begin
                            instr_address <= instr_address + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                        if (instr_count != 8'hFF) begin
                            instr_count <= instr_count + 8'd1;
                        end
                        if (last_flag) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized and directed checks against a behavioural fetch model
module tb_instruction_fetch_unit;

    localparam logic [7:0] EOP = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       instr_ready = 1'b0;
    logic [7:0] mem [256];

    logic [7:0] a_addr [2];
    logic [7:0] a_data [2];
    logic [7:0] a_out  [2];
    logic [7:0] a_cnt  [2];
    logic       a_en    [2];
    logic       a_valid [2];
    logic       a_busy  [2];
    logic       a_done  [2];
    logic       a_over  [2];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    initial forever #5 clk = ~clk;

    // instance 0 uses the full address space, instance 1 has MAX_ADDR=3
    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign a_data[g] = a_en[g] ? mem[a_addr[g]] : 8'hFF;
        instruction_fetch_unit #(
            .END_OF_PROGRAM(8'hFF),
            .START_ADDR    (8'd0),
            .MAX_ADDR      ((g == 0) ? 8'd255 : 8'd3)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .instr_address(a_addr[g]),
            .instr_enable (a_en[g]),
            .instr_data   (a_data[g]),
            .instr_out    (a_out[g]),
            .instr_valid  (a_valid[g]),
            .instr_ready  (instr_ready),
            .busy         (a_busy[g]),
            .done         (a_done[g]),
            .overrun      (a_over[g]),
            .instr_count  (a_cnt[g])
        );
    end

    // model phase: 0 idle, 1 reading RAM, 2 offering an instruction, 3 finished
    int         m_ph    [2];
    logic [7:0] m_addr  [2];
    logic [7:0] m_out   [2];
    int         m_cnt   [2];
    bit         m_valid [2];
    bit         m_over  [2];
    bit         m_last  [2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int k, input int maxa);
        logic [7:0] d;
        if (rst) begin
            m_ph[k] = 0; m_addr[k] = 0; m_out[k] = 0; m_cnt[k] = 0;
            m_valid[k] = 0; m_over[k] = 0; m_last[k] = 0;
        end else if (m_ph[k] == 0 || m_ph[k] == 3) begin
            if (start) begin
                m_ph[k] = 1; m_addr[k] = 0; m_cnt[k] = 0; m_over[k] = 0; m_last[k] = 0;
            end
        end else if (m_ph[k] == 1) begin
            d = mem[m_addr[k]];
            if (d == EOP) begin
                m_ph[k] = 3;
            end else begin
                m_out[k] = d;
                m_valid[k] = 1;
                m_ph[k] = 2;
                if (int'(m_addr[k]) == maxa) m_last[k] = 1;
                else m_addr[k] = m_addr[k] + 8'd1;
            end
        end else if (instr_ready) begin
            m_valid[k] = 0;
            m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
            if (m_last[k]) begin
                m_ph[k] = 3;
                m_over[k] = 1;
            end else begin
                m_ph[k] = 1;
            end
        end
    endtask

    int acc[$];
    int addrs[$];
    int vcyc, en_cyc, stall_cyc, hi3;

    always @(posedge clk) begin
        if (a_valid[0] && instr_ready) acc.push_back(int'(a_out[0]));
        if (a_en[0]) begin addrs.push_back(int'(a_addr[0])); en_cyc++; end
        if (a_valid[0]) vcyc++;
        if (a_valid[0] && !instr_ready && a_out[0] == 8'd3) stall_cyc++;
        if (a_en[1] && a_addr[1] > 8'd3) hi3++;
        step(0, 255);
        step(1, 3);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d_addr", k), int'(a_addr[k]), int'(m_addr[k]));
                chk($sformatf("u%0d_enable", k), int'(a_en[k]), int'(m_ph[k] == 1));
                chk($sformatf("u%0d_busy", k), int'(a_busy[k]), int'(m_ph[k] == 1 || m_ph[k] == 2));
                chk($sformatf("u%0d_done", k), int'(a_done[k]), int'(m_ph[k] == 3));
                chk($sformatf("u%0d_valid", k), int'(a_valid[k]), int'(m_valid[k]));
                chk($sformatf("u%0d_out", k), int'(a_out[k]), int'(m_out[k]));
                chk($sformatf("u%0d_overrun", k), int'(a_over[k]), int'(m_over[k]));
                chk($sformatf("u%0d_count", k), int'(a_cnt[k]), m_cnt[k]);
            end
        end
    end

    task automatic clear_mon();
        acc.delete(); addrs.delete();
        vcyc = 0; en_cyc = 0; stall_cyc = 0; hi3 = 0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = EOP;
        mem[0] = 8'd4; mem[1] = 8'd3; mem[2] = 8'd8; mem[3] = 8'd5; mem[4] = EOP;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // mode 0: ready high; 1: stall the instruction 3 for 5 cycles; 2: also pulse start while 3 is held
    task automatic run_to_done(input int mode, input int lim);
        int i = 0;
        int stall_left = 5;
        bit pulsed = 0;
        while (!(a_done[0] && a_done[1]) && i < lim) begin
            @(negedge clk);
            start = 1'b0;
            instr_ready = 1'b1;
            if (mode == 1 && a_valid[0] && a_out[0] == 8'd3 && stall_left > 0) begin
                instr_ready = 1'b0;
                stall_left--;
            end
            if (mode == 2 && a_valid[0] && a_out[0] == 8'd3 && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
            end
            i++;
        end
        @(negedge clk) start = 1'b0;
        chk("run_to_done_in_time", int'(i < lim), 1);
    endtask

    task automatic check_basic_seq(input string tag);
        int exp_seq[4] = '{4, 3, 8, 5};
        chk({tag, "_acc_len"}, acc.size(), 4);
        for (int i = 0; i < 4 && i < acc.size(); i++) chk({tag, "_acc"}, acc[i], exp_seq[i]);
        chk({tag, "_addr_len"}, addrs.size(), 5);
        for (int i = 0; i < addrs.size(); i++) chk({tag, "_addr_seq"}, addrs[i], i);
        chk({tag, "_en_cycles"}, en_cyc, 5);
        chk({tag, "_cnt"}, int'(a_cnt[0]), 4);
        chk({tag, "_over"}, int'(a_over[0]), 0);
        chk({tag, "_done"}, int'(a_done[0]), 1);
        chk({tag, "_max3_over"}, int'(a_over[1]), 1);
        chk({tag, "_max3_cnt"}, int'(a_cnt[1]), 4);
        chk({tag, "_max3_addr4"}, hi3, 0);
    endtask

    initial begin
        int i;
        load_prog();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_valid", int'(a_valid[0]), 0);
        chk("reset_addr", int'(a_addr[0]), 0);
        chk("reset_done", int'(a_done[0]), 0);
        @(negedge clk);

        clear_mon();
        pulse_start();
        run_to_done(0, 100);
        check_basic_seq("plain");
        chk("plain_valid_cycles", vcyc, 4);

        clear_mon();
        pulse_start();
        chk("restart_done_clr", int'(a_done[0]), 0);
        chk("restart_cnt_clr", int'(a_cnt[0]), 0);
        chk("restart_over_clr", int'(a_over[1]), 0);
        run_to_done(1, 100);
        check_basic_seq("stall");
        chk("stall_cycles", stall_cyc, 5);

        clear_mon();
        pulse_start();
        run_to_done(2, 100);
        check_basic_seq("start_in_hold");

        clear_mon();
        pulse_start();
        i = 0;
        while (!a_valid[0] && i < 20) begin @(negedge clk); i++; end
        chk("reach_hold", int'(a_valid[0]), 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("hold_rst_valid", int'(a_valid[0]), 0);
        chk("hold_rst_out", int'(a_out[0]), 0);
        chk("hold_rst_addr", int'(a_addr[0]), 0);
        chk("hold_rst_busy", int'(a_busy[0]), 0);
        chk("hold_rst_en", int'(a_en[0]), 0);
        clear_mon();
        pulse_start();
        run_to_done(0, 100);
        check_basic_seq("after_rst");

        mem[0] = EOP;
        clear_mon();
        pulse_start();
        chk("eop_first_done_early", int'(a_done[0]), 0);
        @(negedge clk);
        chk("eop_first_done", int'(a_done[0]), 1);
        chk("eop_first_cnt", int'(a_cnt[0]), 0);
        chk("eop_first_valid_cycles", vcyc, 0);

        for (int j = 0; j < 256; j++) mem[j] = 8'h11;
        clear_mon();
        pulse_start();
        run_to_done(0, 700);
        chk("full_acc_len", acc.size(), 256);
        chk("full_addr_len", addrs.size(), 256);
        chk("full_cnt_sat", int'(a_cnt[0]), 255);
        chk("full_over", int'(a_over[0]), 1);

        for (int it = 0; it < 40; it++) begin
            int len = $urandom_range(0, 10);
            for (int j = 0; j < 256; j++) mem[j] = 8'($urandom_range(0, 254));
            if ($urandom_range(0, 3) != 0) mem[len] = EOP;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 14) == 0);
                rst = ($urandom_range(0, 199) == 0);
                instr_ready = ($urandom_range(0, 2) != 0);
            end
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
